// File: rtl/udp_status_pkg.sv
// Shared types and constants for udp_status_responder.
// STATUS_CHECKSUM_EN appends an XOR checksum word, giving 5-word replies instead of 4.
package udp_status_pkg;
  typedef enum logic {IDLE, SEND} state_t;

  localparam int WORD_IDX_W = 3;
  localparam logic [31:0] DEFAULT_MAGIC = 32'h4C43_4231;

  localparam logic [WORD_IDX_W-1:0] W_MAGIC  = 3'd0;
  localparam logic [WORD_IDX_W-1:0] W_SEQ    = 3'd1;
  localparam logic [WORD_IDX_W-1:0] W_FRAMES = 3'd2;
  localparam logic [WORD_IDX_W-1:0] W_ERRS   = 3'd3;
  localparam logic [WORD_IDX_W-1:0] W_CSUM   = 3'd4;

`ifdef STATUS_CHECKSUM_EN
  localparam int NUM_WORDS = 5;
`else
  localparam int NUM_WORDS = 4;
`endif
  localparam logic [WORD_IDX_W-1:0] LAST_IDX    = WORD_IDX_W'(NUM_WORDS - 1);
  localparam logic [15:0]           PAYLOAD_LEN = 16'(NUM_WORDS * 4);
endpackage

// File: rtl/udp_status_responder.sv
// Streams fixed-length UDP status replies into the liteeth udp_sink, one request buffered.
// STATUS_CHECKSUM_EN adds a fifth word holding the XOR of the first four.
module udp_status_responder
  import udp_status_pkg::*;
#(
  parameter logic [15:0] LOCAL_PORT = 16'd6000,
  parameter logic [31:0] MAGIC      = DEFAULT_MAGIC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_ip_address,
  input  logic [15:0] req_port,
  input  logic [31:0] stat_frames,
  input  logic [15:0] stat_errors,
  output logic        udp_sink_valid,
  output logic        udp_sink_last,
  input  logic        udp_sink_ready,
  output logic [15:0] udp_sink_src_port,
  output logic [15:0] udp_sink_dst_port,
  output logic [31:0] udp_sink_ip_address,
  output logic [15:0] udp_sink_length,
  output logic [31:0] udp_sink_data,
  output logic [3:0]  udp_sink_error
);
  state_t state, state_next;
  logic [WORD_IDX_W-1:0] idx;
  logic [31:0] seq_num, snap_frames, pend_ip, start_ip;
  logic [15:0] drop_count, drop_next, snap_errors, snap_drops, pend_port, start_port;
  logic        pending, in_send, xfer, at_last, slot_full, use_req, start;

  assign udp_sink_src_port = LOCAL_PORT;
  assign udp_sink_length   = PAYLOAD_LEN;
  assign udp_sink_error    = 4'd0;

  assign in_send   = (state == SEND);
  assign xfer      = in_send && udp_sink_ready;
  assign at_last   = (idx == LAST_IDX);
  // A request arriving alongside the final transfer counts as pending for the restart.
  assign slot_full = pending || (in_send && req_valid);
  assign start     = (!in_send && (pending || req_valid)) || (xfer && at_last && slot_full);
  // Newest request wins in SEND; in IDLE a drained slot has priority.
  assign use_req    = req_valid && !(!in_send && pending);
  assign start_ip   = use_req ? req_ip_address : pend_ip;
  assign start_port = use_req ? req_port : pend_port;
  assign drop_next  = (in_send && req_valid && pending && drop_count != 16'hFFFF)
                      ? drop_count + 16'd1 : drop_count;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    udp_sink_valid = 1'b0;
    case (state)
      IDLE: if (pending || req_valid) state_next = SEND;
      SEND: begin
        udp_sink_valid = 1'b1;
        if (xfer && at_last && !slot_full) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx                 <= '0;
      seq_num             <= '0;
      drop_count          <= '0;
      pending             <= 1'b0;
      pend_ip             <= '0;
      pend_port           <= '0;
      udp_sink_ip_address <= '0;
      udp_sink_dst_port   <= '0;
      snap_frames         <= '0;
      snap_errors         <= '0;
      snap_drops          <= '0;
    end else begin
      drop_count <= drop_next;
      if (in_send && req_valid) begin
        pending   <= 1'b1;
        pend_ip   <= req_ip_address;
        pend_port <= req_port;
      end
      if (xfer) idx <= at_last ? '0 : idx + 1'b1;
      if (xfer && at_last) seq_num <= seq_num + 32'd1;
      if (start) begin
        pending             <= 1'b0;
        idx                 <= '0;
        udp_sink_ip_address <= start_ip;
        udp_sink_dst_port   <= start_port;
        snap_frames         <= stat_frames;
        snap_errors         <= stat_errors;
        snap_drops          <= drop_next;
      end
    end
  end

  assign udp_sink_last = in_send && at_last;

  always_comb begin
    udp_sink_data = '0;
    if (in_send) begin
      case (idx)
        W_MAGIC:  udp_sink_data = MAGIC;
        W_SEQ:    udp_sink_data = seq_num;
        W_FRAMES: udp_sink_data = snap_frames;
        W_ERRS:   udp_sink_data = {snap_drops, snap_errors};
`ifdef STATUS_CHECKSUM_EN
        W_CSUM:   udp_sink_data = MAGIC ^ seq_num ^ snap_frames ^ {snap_drops, snap_errors};
`endif
        default:  udp_sink_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_status_responder.sv
// Self-checking bench for udp_status_responder: directed scenarios plus randomized traffic
// against a packet-level reference model (honours STATUS_CHECKSUM_EN).
module tb_udp_status_responder;
`ifdef STATUS_CHECKSUM_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif
  localparam logic [31:0] MAGIC_C = 32'h4C434231;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_ip_address = '0;
  logic [15:0] req_port = '0;
  logic [31:0] stat_frames = '0;
  logic [15:0] stat_errors = '0;
  logic        udp_sink_valid, udp_sink_last, udp_sink_ready;
  logic [15:0] udp_sink_src_port, udp_sink_dst_port, udp_sink_length;
  logic [31:0] udp_sink_ip_address, udp_sink_data;
  logic [3:0]  udp_sink_error;

  int n_checks = 0;
  int n_pass = 0;

  initial udp_sink_ready = 1'b1;
  always #5 clock = ~clock;

  udp_status_responder dut (
    .clock(clock), .reset(reset), .req_valid(req_valid),
    .req_ip_address(req_ip_address), .req_port(req_port),
    .stat_frames(stat_frames), .stat_errors(stat_errors),
    .udp_sink_valid(udp_sink_valid), .udp_sink_last(udp_sink_last),
    .udp_sink_ready(udp_sink_ready), .udp_sink_src_port(udp_sink_src_port),
    .udp_sink_dst_port(udp_sink_dst_port), .udp_sink_ip_address(udp_sink_ip_address),
    .udp_sink_length(udp_sink_length), .udp_sink_data(udp_sink_data),
    .udp_sink_error(udp_sink_error)
  );

  // Reference model: a reply is a prebuilt word array walked by a pointer.
  logic        m_busy = 1'b0;
  int          m_pos = 0;
  logic [31:0] m_words [5];
  logic [31:0] m_ip = '0, m_seq = '0, m_pip = '0;
  logic [15:0] m_port = '0, m_drop = '0, m_pport = '0;
  logic        m_pend = 1'b0;

  task automatic m_start(input logic [31:0] ip, input logic [15:0] port);
    m_busy = 1'b1;
    m_pos  = 0;
    m_ip   = ip;
    m_port = port;
    m_words[0] = MAGIC_C;
    m_words[1] = m_seq;
    m_words[2] = stat_frames;
    m_words[3] = {m_drop, stat_errors};
    m_words[4] = m_words[0] ^ m_words[1] ^ m_words[2] ^ m_words[3];
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0; m_pos = 0; m_seq = '0; m_drop = '0; m_pend = 1'b0;
      m_ip = '0; m_port = '0;
    end else if (!m_busy) begin
      if (req_valid) m_start(req_ip_address, req_port);
    end else begin
      if (req_valid) begin
        if (m_pend && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        m_pend = 1'b1; m_pip = req_ip_address; m_pport = req_port;
      end
      if (udp_sink_ready) begin
        if (m_pos == N - 1) begin
          m_seq = m_seq + 32'd1;
          if (m_pend) begin
            m_pend = 1'b0;
            m_start(m_pip, m_pport);
          end else m_busy = 1'b0;
        end else m_pos = m_pos + 1;
      end
    end
  end

  logic [81:0] obs, expv;
  assign obs  = {udp_sink_valid, udp_sink_last, udp_sink_data, udp_sink_ip_address, udp_sink_dst_port};
  assign expv = {m_busy, m_busy && (m_pos == N - 1), m_busy ? m_words[m_pos] : 32'd0, m_ip, m_port};

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (obs !== {2'b00, 32'd0, 32'd0, 16'd0})
      $display("FAIL reset_state got %h exp %h", obs, {2'b00, 32'd0, 32'd0, 16'd0});
    else n_pass++;
    n_checks++;
    if (udp_sink_length !== 16'(N * 4)) $display("FAIL length got %0d exp %0d", udp_sink_length, N * 4);
    else n_pass++;
    n_checks++;
    if (udp_sink_src_port !== 16'd6000) $display("FAIL src_port got %0d exp 6000", udp_sink_src_port);
    else n_pass++;
    n_checks++;
    if (udp_sink_error !== 4'd0) $display("FAIL error got %h exp 0", udp_sink_error);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    logic [31:0] want [5];
    want[0] = MAGIC_C; want[1] = 32'd0; want[2] = 32'd7; want[3] = 32'd2; want[4] = 32'h4C434234;
    stat_frames = 32'd7; stat_errors = 16'd2; udp_sink_ready = 1'b1;
    req_valid = 1'b1; req_ip_address = 32'hC0A80102; req_port = 16'd5000;
    for (int i = 0; i <= N; i++) begin
      @(negedge clock);
      req_valid = 1'b0;
      n_checks++;
      if (i < N) begin
        if (obs !== {1'b1, i == N - 1, want[i], 32'hC0A80102, 16'd5000})
          $display("FAIL basic_word%0d got %h exp %h", i, obs, {1'b1, i == N - 1, want[i], 32'hC0A80102, 16'd5000});
        else n_pass++;
      end else begin
        if (udp_sink_valid !== 1'b0) $display("FAIL basic_end_valid got %b exp 0", udp_sink_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    logic [31:0] frames0;
    frames0 = $urandom;
    stat_frames = frames0;
    req_valid = 1'b1; req_ip_address = $urandom; req_port = 16'($urandom);
    for (int i = 0; i < N + 5; i++) begin
      @(negedge clock);
      req_valid = 1'b0;
      n_checks++;
      if (obs !== expv) $display("FAIL bp_cycle%0d got %h exp %h", i, obs, expv);
      else n_pass++;
      if (i >= 3 && i <= 5) begin
        n_checks++;
        if ({udp_sink_last, udp_sink_data} !== {1'b0, frames0})
          $display("FAIL bp_hold%0d got %h exp %h", i, {udp_sink_last, udp_sink_data}, {1'b0, frames0});
        else n_pass++;
      end
      udp_sink_ready = !(i >= 2 && i <= 4);
      stat_frames = $urandom;
      if (udp_sink_valid && udp_sink_ready) xfers++;
    end
    n_checks++;
    if (xfers !== N) $display("FAIL bp_xfers got %0d exp %0d", xfers, N);
    else n_pass++;
    udp_sink_ready = 1'b1;
  endtask

  task automatic test_pending_drop();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    udp_sink_ready = 1'b1; stat_errors = 16'h0055;
    req_valid = 1'b1; req_ip_address = 32'h0A000001; req_port = 16'd1;
    for (int i = 0; i < 2 * N + 1; i++) begin
      @(negedge clock);
      n_checks++;
      if (obs !== expv) $display("FAIL pend_cycle%0d got %h exp %h", i, obs, expv);
      else n_pass++;
      if (i < 2 * N) begin
        n_checks++;
        if (udp_sink_valid !== 1'b1) $display("FAIL pend_gap%0d got %b exp 1", i, udp_sink_valid);
        else n_pass++;
      end
      if (i == N) begin
        n_checks++;
        if (udp_sink_dst_port !== 16'd3) $display("FAIL pend_port got %0d exp 3", udp_sink_dst_port);
        else n_pass++;
      end
      if (i == N + 1) begin
        n_checks++;
        if (udp_sink_data !== 32'd1) $display("FAIL pend_seq got %h exp 1", udp_sink_data);
        else n_pass++;
      end
      if (i == N + 3) begin
        n_checks++;
        if (udp_sink_data !== 32'h00010055) $display("FAIL pend_drop got %h exp 00010055", udp_sink_data);
        else n_pass++;
      end
      req_valid = (i < 2);
      req_port = 16'(i + 2);
    end
  endtask

  task automatic test_edge_req();
    req_valid = 1'b1; req_port = 16'd10; stat_errors = 16'h0000;
    for (int i = 0; i < 2 * N + 1; i++) begin
      @(negedge clock);
      n_checks++;
      if (obs !== expv) $display("FAIL edge_cycle%0d got %h exp %h", i, obs, expv);
      else n_pass++;
      if (i == N) begin
        n_checks++;
        if ({udp_sink_valid, udp_sink_dst_port} !== {1'b1, 16'd11})
          $display("FAIL edge_nogap got %h exp %h", {udp_sink_valid, udp_sink_dst_port}, {1'b1, 16'd11});
        else n_pass++;
      end
      if (i == N + 3) begin
        n_checks++;
        if (udp_sink_data[31:16] !== 16'd1) $display("FAIL edge_drop got %h exp 1", udp_sink_data[31:16]);
        else n_pass++;
      end
      req_valid = (i == N - 1);
      req_port = 16'd11;
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_port = 16'd20;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (udp_sink_valid !== 1'b0) $display("FAIL rst_mid_valid got %b exp 0", udp_sink_valid);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (udp_sink_valid !== 1'b0) $display("FAIL rst_no_resend got %b exp 0", udp_sink_valid);
    else n_pass++;
    req_valid = 1'b1; req_port = 16'd21;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({udp_sink_valid, udp_sink_data} !== {1'b1, 32'd0})
      $display("FAIL rst_seq got %h exp %h", {udp_sink_valid, udp_sink_data}, {1'b1, 32'd0});
    else n_pass++;
    repeat (N) @(negedge clock);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      n_checks++;
      if (obs !== expv) $display("FAIL rand_cycle%0d got %h exp %h", i, obs, expv);
      else n_pass++;
      req_valid      = (i < 560) && ($urandom_range(0, 5) == 0);
      req_ip_address = $urandom;
      req_port       = 16'($urandom);
      stat_frames    = $urandom;
      stat_errors    = 16'($urandom);
      udp_sink_ready = (i >= 560) || ($urandom_range(0, 9) < 7);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_pending_drop();
    test_edge_req();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
